// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the program-flow controller: opcode encodings, the
// opcode field position inside an instruction word, and the sequencer state
// encoding.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  // Opcode field: top 4 bits of the 28-bit instruction word.
  localparam int OPC_W     = 4;
  localparam int OPC_HI    = 27;
  localparam int OPC_LO    = 24;
  localparam int PAYLOAD_W = 24;

  // Opcode encodings.
  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI   = 4'h1;
  localparam logic [OPC_W-1:0] OP_STO   = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_IMUL2 = 4'h8;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'hC;
  localparam logic [OPC_W-1:0] OP_BZ    = 4'hD;
  localparam logic [OPC_W-1:0] OP_BNZ   = 4'hE;

  // Sequencer states.
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Watchdog counter with clear/enable plus a saturating running total.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, clears both counts
//   i_clr   : clears the watchdog count (has priority over i_en)
//   i_en    : advances the watchdog count and the total
//   o_tc    : watchdog count is at its last value (TC-1)
//   o_total : saturating count of enabled cycles, cleared only by reset
// -----------------------------------------------------------------------------
module wait_counter #(
  parameter int TC    = 64,
  parameter int TOT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic             o_tc,
  output logic [TOT_W-1:0] o_total
);

  localparam int CNT_W = (TC > 1) ? $clog2(TC) : 1;
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TC - 1);

  logic [CNT_W-1:0] r_count;
  logic [TOT_W-1:0] r_total;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_total <= '0;
    end else begin
      if (i_clr) begin
        r_count <= '0;
      end else if (i_en) begin
        r_count <= r_count + CNT_W'(1);
      end
      // The total is independent of the watchdog clear and sticks at all-ones.
      if (i_en && (r_total != {TOT_W{1'b1}})) begin
        r_total <= r_total + TOT_W'(1);
      end
    end
  end

  assign o_tc    = (r_count == TC_LAST);
  assign o_total = r_total;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the instruction pointer into the combinational instruction ROM and
// registers each fetched word into the issue slot. Stalls issue while the
// multi-cycle multiplier runs IMUL2 (with a watchdog) and redirects fetch on
// taken branches, flushing the word already fetched from the old address.
//   Clock / Reset        : clock, synchronous active-high reset
//   oIP / iInstruction   : ROM address and the ROM word at that address
//   oCurrentInstruction  : issued instruction, oIssueValid=0 marks a bubble
//   iBranchTaken/Target  : taken-branch redirect from the ALU
//   oMulStart / iMulDone : multiplier start pulse and completion
//   oMulTimeout          : sticky flag, watchdog forced a resume
//   oStallCycles         : saturating count of multiplier wait cycles
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int INSTR_W     = 28,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oIP,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [INSTR_W-1:0] oCurrentInstruction,
  output logic               oIssueValid,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic               oMulStart,
  input  logic               iMulDone,
  output logic               oMulTimeout,
  output logic [15:0]        oStallCycles
);

  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {(INSTR_W-OPC_W){1'b0}}};

  seq_state_t         r_state;
  logic [ADDR_W-1:0]  r_ip;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_timeout;

  logic [OPC_W-1:0]   w_opcode;
  logic               w_in_run;
  logic               w_in_wait;
  logic               w_mul_start;
  logic               w_branch;
  logic               w_wd_tc;
  logic               w_wait_exit;
  logic [ADDR_W-1:0]  w_ip_inc;
  logic [15:0]        w_stall_total;

  assign w_opcode  = r_instr[INSTR_W-1 -: OPC_W];
  assign w_in_run  = (r_state == ST_RUN);
  assign w_in_wait = (r_state == ST_MUL_WAIT);
  assign w_ip_inc  = r_ip + ADDR_W'(1);

  // Only a live IMUL2 in RUN starts the multiplier; bubbles never do.
  assign w_mul_start = w_in_run && r_valid && (w_opcode == OP_IMUL2);

  // A branch is honoured only for a live, non-IMUL2 issued instruction.
  assign w_branch = w_in_run && r_valid && (w_opcode != OP_IMUL2) && iBranchTaken;

  // Watchdog terminal count means this is the MUL_TIMEOUT-th wait cycle.
  assign w_wait_exit = w_in_wait && (iMulDone || w_wd_tc);

  wait_counter #(
    .TC    (MUL_TIMEOUT),
    .TOT_W (16)
  ) u_wait_counter (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_clr   (w_in_run || w_wait_exit),
    .i_en    (w_in_wait),
    .o_tc    (w_wd_tc),
    .o_total (w_stall_total)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_RUN;
      r_ip      <= '0;
      r_instr   <= NOP_WORD;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mul_start) begin
            // Hold the IP; the word at oIP is fetched again on resume.
            r_state <= ST_MUL_WAIT;
            r_valid <= 1'b0;
          end else if (w_branch) begin
            // Discard the word fetched from the fall-through address.
            r_ip    <= iBranchTarget;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
          end else begin
            r_instr <= iInstruction;
            r_valid <= 1'b1;
            r_ip    <= w_ip_inc;
          end
        end
        ST_MUL_WAIT: begin
          if (w_wait_exit) begin
            r_instr <= iInstruction;
            r_valid <= 1'b1;
            r_ip    <= w_ip_inc;
            r_state <= ST_RUN;
            if (!iMulDone) begin
              r_timeout <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign oIP                 = r_ip;
  assign oCurrentInstruction = r_instr;
  assign oIssueValid         = r_valid;
  assign oMulStart           = w_mul_start;
  assign oMulTimeout         = r_timeout;
  assign oStallCycles        = w_stall_total;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int ADDR_W      = 16;
  localparam int INSTR_W     = 28;
  localparam int MUL_TIMEOUT = 64;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic [ADDR_W-1:0]  oIP;
  logic [INSTR_W-1:0] iInstruction;
  logic [INSTR_W-1:0] oCurrentInstruction;
  logic               oIssueValid;
  logic               iBranchTaken = 1'b0;
  logic [ADDR_W-1:0]  iBranchTarget = '0;
  logic               oMulStart;
  logic               iMulDone = 1'b0;
  logic               oMulTimeout;
  logic [15:0]        oStallCycles;

  logic [INSTR_W-1:0] rom_mem [0:255];
  assign iInstruction = rom_mem[oIP[7:0]];

  fetch_sequencer #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .MUL_TIMEOUT(MUL_TIMEOUT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(iInstruction),
    .oCurrentInstruction(oCurrentInstruction), .oIssueValid(oIssueValid),
    .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oMulStart(oMulStart), .iMulDone(iMulDone), .oMulTimeout(oMulTimeout),
    .oStallCycles(oStallCycles)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [INSTR_W-1:0] w(input logic [3:0] op, input int a);
    return {op, 24'(a)};
  endfunction

  task automatic load_fixed_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = w(OP_STO, i);
    rom_mem[0] = w(OP_NOP, 0);
    rom_mem[3] = w(OP_IMUL2, 3);
    rom_mem[5] = w(OP_JMP, 5);
  endtask

  task automatic do_reset();
    Reset = 1'b1; iBranchTaken = 1'b0; iMulDone = 1'b0; iBranchTarget = '0;
    tick(); tick();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic               br;
    logic [ADDR_W-1:0]  tgt;
    logic               done;
    logic [ADDR_W-1:0]  ip;
    logic               vld;
    logic [INSTR_W-1:0] instr;
    logic               ms;
    logic [15:0]        stall;
  } vec_t;

  function automatic vec_t mk(input logic br, input logic [15:0] tgt, input logic done,
                              input logic [15:0] ip, input logic vld,
                              input logic [INSTR_W-1:0] instr, input logic ms,
                              input logic [15:0] stall);
    vec_t v;
    v.br = br; v.tgt = tgt; v.done = done; v.ip = ip; v.vld = vld;
    v.instr = instr; v.ms = ms; v.stall = stall;
    return v;
  endfunction

  // Reference model state: issue slot contents, whether the multiplier is
  // busy, and how many wait cycles have elapsed in the current multiply.
  logic [ADDR_W-1:0]  m_ip;
  logic               m_vld;
  logic [INSTR_W-1:0] m_instr;
  bit                 m_busy;
  int                 m_waited;
  int                 m_stall;
  bit                 m_to;

  task automatic model_reset();
    m_ip = '0; m_vld = 1'b0; m_instr = w(OP_NOP, 0);
    m_busy = 0; m_waited = 0; m_stall = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic rst, input logic br, input logic [15:0] tgt,
                            input logic done);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (m_vld && m_instr[27:24] == OP_IMUL2) begin
        m_busy = 1; m_waited = 0; m_vld = 1'b0;
      end else if (m_vld && br) begin
        m_ip = tgt; m_vld = 1'b0; m_instr = w(OP_NOP, 0);
      end else begin
        m_instr = rom_mem[m_ip[7:0]]; m_vld = 1'b1; m_ip = m_ip + 16'd1;
      end
    end else begin
      m_waited++;
      if (m_stall < 65535) m_stall++;
      if (done || m_waited == MUL_TIMEOUT) begin
        if (!done) m_to = 1;
        m_busy = 0;
        m_instr = rom_mem[m_ip[7:0]]; m_vld = 1'b1; m_ip = m_ip + 16'd1;
      end
    end
  endtask

  vec_t tbl [14];
  int   first_k;
  int   pulses;

  initial begin
    // ---------------- table-driven directed sequence ----------------
    load_fixed_rom();
    do_reset();
    check("rst_ip",    32'(oIP), 32'd0);
    check("rst_vld",   32'(oIssueValid), 32'd0);
    check("rst_instr", 32'(oCurrentInstruction), 32'(w(OP_NOP, 0)));
    check("rst_ms",    32'(oMulStart), 32'd0);
    check("rst_to",    32'(oMulTimeout), 32'd0);
    check("rst_stall", 32'(oStallCycles), 32'd0);

    tbl[0]  = mk(0, 16'h0000, 0, 16'h0001, 1, w(OP_NOP, 0),       0, 0);
    tbl[1]  = mk(0, 16'h0000, 0, 16'h0002, 1, w(OP_STO, 1),       0, 0);
    tbl[2]  = mk(0, 16'h0000, 0, 16'h0003, 1, w(OP_STO, 2),       0, 0);
    tbl[3]  = mk(0, 16'h0000, 0, 16'h0004, 1, w(OP_IMUL2, 3),     1, 0);
    tbl[4]  = mk(1, 16'h0010, 0, 16'h0004, 0, w(OP_IMUL2, 3),     0, 0);
    tbl[5]  = mk(1, 16'h0020, 0, 16'h0004, 0, w(OP_IMUL2, 3),     0, 1);
    tbl[6]  = mk(0, 16'h0000, 0, 16'h0004, 0, w(OP_IMUL2, 3),     0, 2);
    tbl[7]  = mk(0, 16'h0000, 0, 16'h0004, 0, w(OP_IMUL2, 3),     0, 3);
    tbl[8]  = mk(0, 16'h0000, 0, 16'h0004, 0, w(OP_IMUL2, 3),     0, 4);
    tbl[9]  = mk(0, 16'h0000, 1, 16'h0005, 1, w(OP_STO, 4),       0, 5);
    tbl[10] = mk(0, 16'h0000, 0, 16'h0006, 1, w(OP_JMP, 5),       0, 5);
    tbl[11] = mk(1, 16'h0010, 0, 16'h0010, 0, w(OP_NOP, 0),       0, 5);
    tbl[12] = mk(0, 16'h0000, 1, 16'h0011, 1, w(OP_STO, 16'h10),  0, 5);
    tbl[13] = mk(0, 16'h0000, 0, 16'h0012, 1, w(OP_STO, 16'h11),  0, 5);

    for (int i = 0; i < 14; i++) begin
      iBranchTaken = tbl[i].br; iBranchTarget = tbl[i].tgt; iMulDone = tbl[i].done;
      tick();
      check($sformatf("tbl%0d_ip", i),    32'(oIP), 32'(tbl[i].ip));
      check($sformatf("tbl%0d_vld", i),   32'(oIssueValid), 32'(tbl[i].vld));
      check($sformatf("tbl%0d_instr", i), 32'(oCurrentInstruction), 32'(tbl[i].instr));
      check($sformatf("tbl%0d_ms", i),    32'(oMulStart), 32'(tbl[i].ms));
      check($sformatf("tbl%0d_stall", i), 32'(oStallCycles), 32'(tbl[i].stall));
      check($sformatf("tbl%0d_to", i),    32'(oMulTimeout), 32'd0);
    end
    iBranchTaken = 0; iMulDone = 0;

    // ---------------- multiplier watchdog timeout ----------------
    do_reset();
    for (int k = 1; k <= 4; k++) tick();
    check("to_start", 32'(oMulStart), 32'd1);
    pulses = 1;
    first_k = -1;
    for (int k = 5; k < 205; k++) begin
      tick();
      if (oMulStart) pulses++;
      if (oIssueValid) begin
        first_k = k;
        break;
      end
    end
    check("to_resume_edge", 32'(first_k), 32'd69);
    check("to_flag",        32'(oMulTimeout), 32'd1);
    check("to_stall",       32'(oStallCycles), 32'd64);
    check("to_pulses",      32'(pulses), 32'd1);
    check("to_ip",          32'(oIP), 32'd5);
    check("to_instr",       32'(oCurrentInstruction), 32'(w(OP_STO, 4)));
    iMulDone = 1; tick(); iMulDone = 0;
    tick(); tick(); tick();
    check("to_sticky",       32'(oMulTimeout), 32'd1);
    check("to_stall_hold",   32'(oStallCycles), 32'd64);
    check("to_ip_after",     32'(oIP), 32'd9);

    // ---------------- reset in the 3rd MUL_WAIT cycle ----------------
    do_reset();
    for (int k = 1; k <= 7; k++) tick();
    check("mr_waiting", 32'(oIssueValid), 32'd0);
    Reset = 1; tick(); Reset = 0;
    check("mr_ip",    32'(oIP), 32'd0);
    check("mr_vld",   32'(oIssueValid), 32'd0);
    check("mr_stall", 32'(oStallCycles), 32'd0);
    check("mr_ms",    32'(oMulStart), 32'd0);
    check("mr_to",    32'(oMulTimeout), 32'd0);
    iMulDone = 1; tick(); iMulDone = 0;
    check("mr_late_ip",    32'(oIP), 32'd1);
    check("mr_late_vld",   32'(oIssueValid), 32'd1);
    check("mr_late_instr", 32'(oCurrentInstruction), 32'(w(OP_NOP, 0)));
    tick();
    check("mr_run_ip",    32'(oIP), 32'd2);
    check("mr_run_stall", 32'(oStallCycles), 32'd0);

    // ---------------- oIP wrap at 16'hFFFF ----------------
    do_reset();
    tick();
    iBranchTaken = 1; iBranchTarget = 16'hFFFE; tick(); iBranchTaken = 0;
    check("wr_br_ip",  32'(oIP), 32'hFFFE);
    check("wr_br_vld", 32'(oIssueValid), 32'd0);
    tick();
    check("wr_ffff",   32'(oIP), 32'hFFFF);
    tick();
    check("wr_zero",   32'(oIP), 32'd0);
    check("wr_instr",  32'(oCurrentInstruction), 32'(w(OP_STO, 255)));
    check("wr_vld",    32'(oIssueValid), 32'd1);

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 256; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) op = OP_IMUL2;
      rom_mem[i] = {op, 24'($urandom)};
    end
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      logic r_rst, r_br, r_done;
      logic [15:0] r_tgt;
      int rate;
      rate   = (c < 2000) ? 20 : 3;
      r_rst  = ($urandom_range(0, 299) == 0);
      r_br   = ($urandom_range(0, 3) == 0);
      r_tgt  = 16'($urandom);
      r_done = ($urandom_range(0, 99) < rate);
      Reset = r_rst; iBranchTaken = r_br; iBranchTarget = r_tgt; iMulDone = r_done;
      model_edge(r_rst, r_br, r_tgt, r_done);
      tick();
      check("rnd_ip",    32'(oIP), 32'(m_ip));
      check("rnd_vld",   32'(oIssueValid), 32'(m_vld));
      check("rnd_instr", 32'(oCurrentInstruction), 32'(m_instr));
      check("rnd_ms",    32'(oMulStart),
            32'((!m_busy && m_vld && m_instr[27:24] == OP_IMUL2) ? 1 : 0));
      check("rnd_stall", 32'(oStallCycles), 32'(m_stall));
      check("rnd_to",    32'(oMulTimeout), 32'(m_to));
    end
    Reset = 0; iBranchTaken = 0; iMulDone = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
